// File: rtl/rggen_sw_access_arbiter_if.sv
// Bundled request, response and register-block access signals for the
// software access arbiter. The slave modport is the arbiter's view; master is
// the view of the requesters and register block around it.
interface rggen_sw_access_arbiter_if #(
    parameter int unsigned REQUESTERS    = 2,
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned DATA_WIDTH    = 32
);
    logic [REQUESTERS-1:0]               req_valid;
    logic [REQUESTERS-1:0]               req_ready;
    logic [REQUESTERS*ADDRESS_WIDTH-1:0] req_address;
    logic [REQUESTERS-1:0]               req_write;
    logic [REQUESTERS*DATA_WIDTH-1:0]    req_write_data;
    logic [REQUESTERS*DATA_WIDTH-1:0]    req_mask;
    logic [REQUESTERS-1:0]               rsp_valid;
    logic [REQUESTERS-1:0]               rsp_ready;
    logic [1:0]                          rsp_status;
    logic [DATA_WIDTH-1:0]               rsp_read_data;
    logic                                access_valid;
    logic [ADDRESS_WIDTH-1:0]            access_address;
    logic                                access_write;
    logic [DATA_WIDTH-1:0]               access_data;
    logic [DATA_WIDTH-1:0]               access_mask;
    logic                                access_ready;
    logic [1:0]                          access_status;
    logic [DATA_WIDTH-1:0]               access_read_data;

    modport slave (
        input  req_valid, req_address, req_write, req_write_data, req_mask, rsp_ready,
        input  access_ready, access_status, access_read_data,
        output req_ready, rsp_valid, rsp_status, rsp_read_data,
        output access_valid, access_address, access_write, access_data, access_mask
    );

    modport master (
        output req_valid, req_address, req_write, req_write_data, req_mask, rsp_ready,
        output access_ready, access_status, access_read_data,
        input  req_ready, rsp_valid, rsp_status, rsp_read_data,
        input  access_valid, access_address, access_write, access_data, access_mask
    );
endinterface

// File: rtl/rggen_sw_access_arbiter.sv
// Round-robin arbiter sharing one register-block software access port among
// several requesters, one outstanding access at a time, with optional timeout.
module rggen_sw_access_arbiter #(
    parameter int unsigned REQUESTERS     = 2,
    parameter int unsigned ADDRESS_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input logic                           i_clk,
    input logic                           i_rst_n,
    rggen_sw_access_arbiter_if.slave      bus
);
    localparam int unsigned IndexWidth = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam int unsigned TimerWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TimerWidth-1:0] TimerLast =
        TimerWidth'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic [IndexWidth-1:0] LastIndex = IndexWidth'(REQUESTERS - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StResponse} state_e;

    state_e                state_q;
    logic [IndexWidth-1:0] pointer_q;
    logic [IndexWidth-1:0] grant_q;
    logic [TimerWidth-1:0] timer_q;

    logic                  pick_found;
    logic [IndexWidth-1:0] pick;

    // Round-robin search: first valid requester after the last one served.
    always_comb begin
        int unsigned           cand;
        logic [IndexWidth-1:0] cand_idx;
        pick_found = 1'b0;
        pick       = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int unsigned i = 1; i <= REQUESTERS; i++) begin
            cand     = (32'(pointer_q) + i) % REQUESTERS;
            cand_idx = IndexWidth'(cand);
            if (!pick_found && bus.req_valid[cand_idx]) begin
                pick_found = 1'b1;
                pick       = cand_idx;
            end
        end
    end

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q            <= StIdle;
            pointer_q          <= LastIndex;
            grant_q            <= '0;
            timer_q            <= '0;
            bus.req_ready      <= '0;
            bus.rsp_valid      <= '0;
            bus.rsp_status     <= '0;
            bus.rsp_read_data  <= '0;
            bus.access_valid   <= 1'b0;
            bus.access_address <= '0;
            bus.access_write   <= 1'b0;
            bus.access_data    <= '0;
            bus.access_mask    <= '0;
        end else begin
            bus.req_ready <= '0;
            unique case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        grant_q            <= pick;
                        bus.req_ready[pick] <= 1'b1;
                        bus.access_valid   <= 1'b1;
                        bus.access_address <= bus.req_address[int'(pick)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                        bus.access_write   <= bus.req_write[pick];
                        bus.access_data    <= bus.req_write_data[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
                        bus.access_mask    <= bus.req_mask[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
                        timer_q            <= '0;
                        state_q            <= StAccess;
                    end
                end
                StAccess: begin
                    if (bus.access_ready) begin
                        bus.access_valid       <= 1'b0;
                        bus.rsp_valid[grant_q] <= 1'b1;
                        bus.rsp_status         <= bus.access_status;
                        // Read data is only meaningful for successful reads.
                        bus.rsp_read_data      <= (bus.access_write || bus.access_status[1]) ?
                                                  '0 : bus.access_read_data;
                        state_q                <= StResponse;
                    end else if ((TIMEOUT_CYCLES > 0) && (timer_q == TimerLast)) begin
                        bus.access_valid       <= 1'b0;
                        bus.rsp_valid[grant_q] <= 1'b1;
                        bus.rsp_status         <= 2'b10;
                        bus.rsp_read_data      <= '0;
                        state_q                <= StResponse;
                    end else begin
                        timer_q <= timer_q + TimerWidth'(1);
                    end
                end
                StResponse: begin
                    // Only the granted requester can close the response.
                    if (bus.rsp_ready[grant_q]) begin
                        pointer_q         <= grant_q;
                        bus.rsp_valid     <= '0;
                        bus.rsp_status    <= '0;
                        bus.rsp_read_data <= '0;
                        state_q           <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_rggen_sw_access_arbiter.sv
// Randomised self-checking bench for rggen_sw_access_arbiter with a
// round-robin reference model kept as a pointer plus pending-request table.
module tb_rggen_sw_access_arbiter;
    localparam int N  = 2;
    localparam int AW = 8;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rggen_sw_access_arbiter_if #(.REQUESTERS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    rggen_sw_access_arbiter_if #(.REQUESTERS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

    rggen_sw_access_arbiter #(
        .REQUESTERS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(0)
    ) dut0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus0.slave)
    );

    rggen_sw_access_arbiter #(
        .REQUESTERS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)
    ) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus1.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            model_ptr;
    bit            pend    [N];
    logic [AW-1:0] p_addr  [N];
    logic          p_write [N];
    logic [DW-1:0] p_data  [N];
    logic [DW-1:0] p_mask  [N];

    function automatic int model_pick();
        for (int i = 1; i <= N; i++) begin
            int c;
            c = (model_ptr + i) % N;
            if (pend[c]) return c;
        end
        return -1;
    endfunction

    task automatic drive_req();
        for (int k = 0; k < N; k++) begin
            bus0.req_valid[k]                = pend[k];
            bus0.req_write[k]                = p_write[k];
            bus0.req_address[k*AW +: AW]     = p_addr[k];
            bus0.req_write_data[k*DW +: DW]  = p_data[k];
            bus0.req_mask[k*DW +: DW]        = p_mask[k];
        end
    endtask

    task automatic new_req(input int k, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] m);
        pend[k]    = 1'b1;
        p_write[k] = wr;
        p_addr[k]  = a;
        p_data[k]  = d;
        p_mask[k]  = m;
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < N; k++) begin
            pend[k] = 1'b0; p_write[k] = 1'b0; p_addr[k] = '0; p_data[k] = '0; p_mask[k] = '0;
        end
        drive_req();
        bus0.rsp_ready = '0; bus0.access_ready = 1'b0;
        bus0.access_status = '0; bus0.access_read_data = '0;
        bus1.req_valid = '0; bus1.req_write = '0; bus1.req_address = '0;
        bus1.req_write_data = '0; bus1.req_mask = '0; bus1.rsp_ready = '0;
        bus1.access_ready = 1'b0; bus1.access_status = '0; bus1.access_read_data = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_ptr = N - 1;
    endtask

    // One full transaction on bus0: grant, access with acc_delay wait cycles,
    // response held for rsp_delay cycles. obs_g is the grant seen on req_ready.
    task automatic run_txn(input string tag, input int acc_delay, input int rsp_delay,
                           input logic [1:0] st, input logic [DW-1:0] rd, output int obs_g);
        int            g;
        logic [N-1:0]  one_hot;
        logic [DW-1:0] exp_data;
        g = model_pick();
        one_hot = N'(1) << g;
        drive_req();
        @(negedge clk);
        obs_g = -1;
        for (int k = 0; k < N; k++) if (bus0.req_ready[k] === 1'b1) obs_g = k;
        checks++;
        if (bus0.req_ready !== one_hot) begin
            errors++;
            $display("FAIL %s grant: req_ready=%b expected %b", tag, bus0.req_ready, one_hot);
        end
        checks++;
        if (bus0.access_valid !== 1'b1 || bus0.access_address !== p_addr[g] ||
            bus0.access_write !== p_write[g] || bus0.access_data !== p_data[g] ||
            bus0.access_mask !== p_mask[g]) begin
            errors++;
            $display("FAIL %s access payload: v=%b a=%h w=%b d=%h m=%h expected 1 %h %b %h %h",
                     tag, bus0.access_valid, bus0.access_address, bus0.access_write,
                     bus0.access_data, bus0.access_mask, p_addr[g], p_write[g], p_data[g],
                     p_mask[g]);
        end
        pend[g] = 1'b0;
        drive_req();
        for (int c = 0; c < acc_delay; c++) begin
            @(negedge clk);
            checks++;
            if (bus0.access_valid !== 1'b1 || bus0.req_ready !== '0 || bus0.rsp_valid !== '0) begin
                errors++;
                $display("FAIL %s access wait %0d: access_valid=%b req_ready=%b rsp_valid=%b expected 1 0 0",
                         tag, c, bus0.access_valid, bus0.req_ready, bus0.rsp_valid);
            end
        end
        bus0.access_ready = 1'b1;
        bus0.access_status = st;
        bus0.access_read_data = rd;
        @(negedge clk);
        bus0.access_ready = 1'b0;
        bus0.access_status = 2'($urandom);
        bus0.access_read_data = $urandom;
        exp_data = (p_write[g] || st[1]) ? '0 : rd;
        checks++;
        if (bus0.access_valid !== 1'b0 || bus0.rsp_valid !== one_hot ||
            bus0.rsp_status !== st || bus0.rsp_read_data !== exp_data) begin
            errors++;
            $display("FAIL %s response: access_valid=%b rsp_valid=%b status=%b data=%h expected 0 %b %b %h",
                     tag, bus0.access_valid, bus0.rsp_valid, bus0.rsp_status, bus0.rsp_read_data,
                     one_hot, st, exp_data);
        end
        for (int c = 0; c < rsp_delay; c++) begin
            bus0.rsp_ready = N'($urandom) & ~one_hot;
            @(negedge clk);
            checks++;
            if (bus0.rsp_valid !== one_hot || bus0.rsp_status !== st ||
                bus0.rsp_read_data !== exp_data || bus0.req_ready !== '0) begin
                errors++;
                $display("FAIL %s response hold %0d: rsp_valid=%b status=%b data=%h req_ready=%b expected %b %b %h 0",
                         tag, c, bus0.rsp_valid, bus0.rsp_status, bus0.rsp_read_data,
                         bus0.req_ready, one_hot, st, exp_data);
            end
        end
        bus0.rsp_ready = one_hot | N'($urandom);
        @(negedge clk);
        bus0.rsp_ready = '0;
        model_ptr = g;
        checks++;
        if (bus0.rsp_valid !== '0 || bus0.rsp_status !== '0 || bus0.rsp_read_data !== '0 ||
            bus0.req_ready !== '0) begin
            errors++;
            $display("FAIL %s response close: rsp_valid=%b status=%b data=%h req_ready=%b expected all 0",
                     tag, bus0.rsp_valid, bus0.rsp_status, bus0.rsp_read_data, bus0.req_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus0.req_ready, bus0.rsp_valid, bus0.rsp_status, bus0.rsp_read_data,
             bus0.access_valid, bus0.access_address, bus0.access_write, bus0.access_data,
             bus0.access_mask} !== '0) begin
            errors++;
            $display("FAIL reset outputs bus0: req_ready=%b rsp_valid=%b access_valid=%b expected all 0",
                     bus0.req_ready, bus0.rsp_valid, bus0.access_valid);
        end
        checks++;
        if ({bus1.req_ready, bus1.rsp_valid, bus1.rsp_status, bus1.rsp_read_data,
             bus1.access_valid, bus1.access_address, bus1.access_write, bus1.access_data,
             bus1.access_mask} !== '0) begin
            errors++;
            $display("FAIL reset outputs bus1: req_ready=%b rsp_valid=%b access_valid=%b expected all 0",
                     bus1.req_ready, bus1.rsp_valid, bus1.access_valid);
        end
        rst_n = 1'b1;
        model_ptr = N - 1;
    endtask

    task automatic test_write_basic();
        int g;
        new_req(0, 1'b1, 8'h10, 32'h0000_00A5, 32'h0000_00FF);
        run_txn("write0", 0, 0, 2'b00, 32'hDEAD_BEEF, g);
    endtask

    task automatic test_read_req1();
        int g;
        new_req(1, 1'b0, 8'h24, 32'h0, 32'hFFFF_FFFF);
        run_txn("read1", 0, 1, 2'b00, 32'h1234_5678, g);
    endtask

    task automatic test_round_robin();
        int g;
        int order [4];
        order = '{0, 1, 0, 1};
        apply_reset();
        for (int k = 0; k < N; k++) new_req(k, 1'($urandom), 8'($urandom), $urandom, $urandom);
        for (int i = 0; i < 4; i++) begin
            run_txn("round_robin", 0, 0, 2'b00, $urandom, g);
            checks++;
            if (g !== order[i]) begin
                errors++;
                $display("FAIL round_robin order %0d: granted %0d expected %0d", i, g, order[i]);
            end
            if (g >= 0) new_req(g, 1'($urandom), 8'($urandom), $urandom, $urandom);
        end
        // Drain whatever is still pending.
        for (int k = 0; k < N; k++) pend[k] = 1'b0;
        drive_req();
        @(negedge clk);
        if (bus0.access_valid === 1'b1) begin
            bus0.access_ready = 1'b1;
            @(negedge clk);
            bus0.access_ready = 1'b0;
            bus0.rsp_ready = '1;
            @(negedge clk);
            bus0.rsp_ready = '0;
        end
        apply_reset();
    endtask

    task automatic test_rsp_hold();
        int g;
        new_req(0, 1'b0, 8'h31, 32'h0, 32'h0000_FFFF);
        new_req(1, 1'b1, 8'h32, 32'hCAFE_0001, 32'hFFFF_0000);
        run_txn("rsp_hold_a", 1, 3, 2'b00, 32'h5555_AAAA, g);
        run_txn("rsp_hold_b", 0, 3, 2'b10, 32'h0, g);
    endtask

    task automatic test_no_timeout();
        int g;
        new_req(0, 1'b0, 8'h40, 32'h0, 32'hFFFF_FFFF);
        run_txn("no_timeout", 30, 0, 2'b00, 32'h0BAD_F00D, g);
    endtask

    task automatic test_timeout();
        int cnt;
        bus1.req_valid = 2'b10;
        bus1.req_write = 2'b00;
        bus1.req_address = {8'h55, 8'h00};
        bus1.access_read_data = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if (bus1.req_ready !== 2'b10) begin
            errors++;
            $display("FAIL timeout grant: req_ready=%b expected 10", bus1.req_ready);
        end
        bus1.req_valid = '0;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus1.access_valid === 1'b1) cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt !== 4) begin
            errors++;
            $display("FAIL timeout access cycles: saw %0d expected 4", cnt);
        end
        checks++;
        if (bus1.rsp_valid !== 2'b10 || bus1.rsp_status !== 2'b10 || bus1.rsp_read_data !== '0) begin
            errors++;
            $display("FAIL timeout response: rsp_valid=%b status=%b data=%h expected 10 10 0",
                     bus1.rsp_valid, bus1.rsp_status, bus1.rsp_read_data);
        end
        bus1.rsp_ready = 2'b10;
        @(negedge clk);
        bus1.rsp_ready = '0;
        checks++;
        if (bus1.rsp_valid !== '0) begin
            errors++;
            $display("FAIL timeout close: rsp_valid=%b expected 00", bus1.rsp_valid);
        end
    endtask

    task automatic test_random();
        int            g;
        logic          wr;
        logic [1:0]    st;
        for (int it = 0; it < 40; it++) begin
            for (int k = 0; k < N; k++)
                if (!pend[k] && $urandom_range(0, 1) == 1)
                    new_req(k, 1'($urandom), 8'($urandom), $urandom, $urandom);
            if (model_pick() < 0)
                new_req(int'($urandom_range(0, N - 1)), 1'($urandom), 8'($urandom), $urandom,
                        $urandom);
            wr = p_write[model_pick()];
            st = (wr && $urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
            run_txn("random", int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), st,
                    $urandom, g);
        end
        for (int k = 0; k < N; k++) begin
            if (pend[k]) run_txn("random_drain", 0, 0, 2'b00, $urandom, g);
        end
    endtask

    task automatic test_reset_mid();
        int g;
        new_req(0, 1'b1, 8'h77, 32'h1111_2222, 32'hFFFF_FFFF);
        drive_req();
        @(negedge clk);
        checks++;
        if (bus0.access_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid setup: access_valid=%b expected 1", bus0.access_valid);
        end
        pend[0] = 1'b0;
        drive_req();
        rst_n = 1'b0;
        bus0.access_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus0.req_ready, bus0.rsp_valid, bus0.rsp_status, bus0.rsp_read_data,
             bus0.access_valid, bus0.access_address, bus0.access_write, bus0.access_data,
             bus0.access_mask} !== '0) begin
            errors++;
            $display("FAIL reset_mid outputs: access_valid=%b rsp_valid=%b addr=%h expected all 0",
                     bus0.access_valid, bus0.rsp_valid, bus0.access_address);
        end
        bus0.access_ready = 1'b0;
        rst_n = 1'b1;
        model_ptr = N - 1;
        @(negedge clk);
        checks++;
        if (bus0.rsp_valid !== '0) begin
            errors++;
            $display("FAIL reset_mid no response: rsp_valid=%b expected 00", bus0.rsp_valid);
        end
        new_req(1, 1'b0, 8'h81, 32'h0, 32'hFFFF_FFFF);
        new_req(0, 1'b0, 8'h80, 32'h0, 32'hFFFF_FFFF);
        run_txn("reset_mid first", 0, 0, 2'b00, 32'hA0A0_0000, g);
        checks++;
        if (g !== 0) begin
            errors++;
            $display("FAIL reset_mid priority: granted %0d expected 0", g);
        end
        run_txn("reset_mid second", 0, 0, 2'b00, 32'hB0B0_0000, g);
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_req1();
        test_round_robin();
        test_rsp_hold();
        test_no_timeout();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 500000", $time);
        $fatal(1);
    end
endmodule
